// File: rtl/prng_lfsr_ticker.sv
// Prescaled 8-bit Galois LFSR ticker: free-running tick/clk1hz plus an enabled LFSR step with wrap flag.
// Optional seed load (SEED_IN/LOAD ports) is compiled in when PRNG_SEED_LOAD_EN is defined.
module prng_lfsr_ticker #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED  = 8'h01,
  parameter int unsigned       DIV   = 50000000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
`ifdef PRNG_SEED_LOAD_EN
  input  logic [WIDTH-1:0] SEED_IN,
  input  logic             LOAD,
`endif
  output logic [WIDTH-1:0] OUT,
  output logic             TICK,
  output logic             clk1hz,
  output logic             STEP,
  output logic             WRAP
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             tick_q, tick_d;
  logic             clk1hz_q, clk1hz_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick_int;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    tick_int = (cnt_q == CW'(DIV - 1));
    cnt_d    = tick_int ? '0 : cnt_q + CW'(1);
    tick_d   = tick_int;
    clk1hz_d = tick_int ? ~clk1hz_q : clk1hz_q;

    // An all-zero state would lock the LFSR, so it is replaced by SEED.
    if (lfsr_q == '0) begin
      shifted = SEED;
    end else begin
      shifted = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end

    lfsr_d = lfsr_q;
    step_d = 1'b0;
    if (tick_int && EN) begin
      lfsr_d = shifted;
      step_d = 1'b1;
    end
`ifdef PRNG_SEED_LOAD_EN
    if (LOAD) begin
      lfsr_d = (SEED_IN == '0) ? SEED : SEED_IN;
      step_d = 1'b1;
    end
`endif
    wrap_d = step_d && (lfsr_d == SEED);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      lfsr_q   <= SEED;
      tick_q   <= 1'b0;
      clk1hz_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      tick_q   <= tick_d;
      clk1hz_q <= clk1hz_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
    end
  end

  assign OUT    = lfsr_q;
  assign TICK   = tick_q;
  assign clk1hz = clk1hz_q;
  assign STEP   = step_q;
  assign WRAP   = wrap_q;

endmodule

// File: tb/tb_prng_lfsr_ticker.sv
// Self-checking bench for prng_lfsr_ticker: vector table, hand sequences and a random-EN run against a sequence model.
// Seed-load checks are included when PRNG_SEED_LOAD_EN is defined.
module tb_prng_lfsr_ticker;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       rstN;
  logic       en;
  logic [7:0] out;
  logic       tick, clkHz, step, wrap;

  logic       rst1N;
  logic       en1;
  logic [7:0] out1;
  logic       tick1, clkHz1, step1, wrap1;

`ifdef PRNG_SEED_LOAD_EN
  logic [7:0] seedIn, seedIn1;
  logic       load, load1;
`endif

  prng_lfsr_ticker #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .DIV(DIV)) dut (
    .CLK(clock), .RST_N(rstN), .EN(en),
`ifdef PRNG_SEED_LOAD_EN
    .SEED_IN(seedIn), .LOAD(load),
`endif
    .OUT(out), .TICK(tick), .clk1hz(clkHz), .STEP(step), .WRAP(wrap)
  );

  prng_lfsr_ticker #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .DIV(1)) dut1 (
    .CLK(clock), .RST_N(rst1N), .EN(en1),
`ifdef PRNG_SEED_LOAD_EN
    .SEED_IN(seedIn1), .LOAD(load1),
`endif
    .OUT(out1), .TICK(tick1), .clk1hz(clkHz1), .STEP(step1), .WRAP(wrap1)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [7:0] out;
    logic       tick;
    logic       clk;
    logic       step;
    logic       wrap;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] seq[256];
  int         passCount = 0;
  int         checkCount = 0;

  // Reference model: edges since release, position in the maximal-length sequence.
  int   n;
  int   idx;
  logic expClk, expTick, expStep, expWrap;

  function automatic logic [7:0] galoisNext(input logic [7:0] v);
    int x;
    x = int'(v);
    if (x % 2 == 1) return 8'(x / 2) ^ 8'hB8;
    return 8'(x / 2);
  endfunction

  task automatic modelReset();
    n = 0; idx = 0;
    expClk = 1'b0; expTick = 1'b0; expStep = 1'b0; expWrap = 1'b0;
  endtask

  task automatic modelEdge(input logic enAtEdge);
    n++;
    expTick = (n % DIV == 0);
    expStep = 1'b0;
    expWrap = 1'b0;
    if (expTick) begin
      expClk = ~expClk;
      if (enAtEdge) begin
        idx = (idx + 1) % 255;
        expStep = 1'b1;
        expWrap = (idx == 0);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic enVal);
    en = enVal;
    @(posedge clock);
    #1;
    modelEdge(enVal);
  endtask

  task automatic checkAll(input string name);
    checkOutput({name, ".OUT"},  32'(out),   32'(seq[idx]));
    checkOutput({name, ".TICK"}, 32'(tick),  32'(expTick));
    checkOutput({name, ".CLK"},  32'(clkHz), 32'(expClk));
    checkOutput({name, ".STEP"}, 32'(step),  32'(expStep));
    checkOutput({name, ".WRAP"}, 32'(wrap),  32'(expWrap));
  endtask

  task automatic doReset();
    rstN = 1'b0;
    @(posedge clock);
    #1;
    modelReset();
    checkOutput("rst.OUT",  32'(out),   'h01);
    checkOutput("rst.TICK", 32'(tick),  0);
    checkOutput("rst.CLK",  32'(clkHz), 0);
    checkOutput("rst.STEP", 32'(step),  0);
    checkOutput("rst.WRAP", 32'(wrap),  0);
    rstN = 1'b1;
  endtask

  initial begin
    int wrapCount;
    rstN = 1'b0; en = 1'b0; rst1N = 1'b0; en1 = 1'b0;
`ifdef PRNG_SEED_LOAD_EN
    seedIn = 8'h00; load = 1'b0; seedIn1 = 8'h00; load1 = 1'b0;
`endif
    seq[0] = 8'h01;
    for (int i = 1; i < 256; i++) seq[i] = galoisNext(seq[i-1]);

    vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'hB8, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'hB8, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'hB8, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'hB8, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h2E, 1'b1, 1'b1, 1'b1, 1'b0};

    // Startup: tick every DIV cycles, first steps of the sequence.
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].en);
      checkOutput($sformatf("vec%0d.OUT", i),  32'(out),   32'(vecs[i].out));
      checkOutput($sformatf("vec%0d.TICK", i), 32'(tick),  32'(vecs[i].tick));
      checkOutput($sformatf("vec%0d.CLK", i),  32'(clkHz), 32'(vecs[i].clk));
      checkOutput($sformatf("vec%0d.STEP", i), 32'(step),  32'(vecs[i].step));
      checkOutput($sformatf("vec%0d.WRAP", i), 32'(wrap),  32'(vecs[i].wrap));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1);
      checkAll("seq");
    end
    checkOutput("seq.B3", 32'(out), 'hB3);

    // Full period: exactly one WRAP, landing on the 255th step.
    doReset();
    wrapCount = 0;
    for (int i = 0; i < 255 * DIV; i++) begin
      applyStimulus(1'b1);
      checkAll("period");
      if (wrap) wrapCount++;
    end
    checkOutput("period.wrapCount", 32'(wrapCount), 1);
    checkOutput("period.OUT", 32'(out), 'h01);
    checkOutput("period.WRAP", 32'(wrap), 1);

    // Hold at 5C with EN low across three ticks.
    doReset();
    for (int i = 0; i < 2 * DIV; i++) applyStimulus(1'b1);
    checkOutput("hold.start", 32'(out), 'h5C);
    for (int i = 0; i < 3 * DIV; i++) begin
      applyStimulus(1'b0);
      checkAll("hold");
      checkOutput("hold.OUT", 32'(out), 'h5C);
    end
    for (int i = 0; i < DIV; i++) applyStimulus(1'b1);
    checkAll("resume");
    checkOutput("resume.OUT", 32'(out), 'h2E);

    // Asynchronous reset mid-run with OUT=17, TICK and clk1hz high.
    doReset();
    for (int i = 0; i < 3 * DIV; i++) applyStimulus(1'b1);
    for (int i = 0; i < DIV; i++) applyStimulus(1'b0);
    for (int i = 0; i < DIV; i++) applyStimulus(1'b1);
    checkOutput("pre.OUT",  32'(out),   'h17);
    checkOutput("pre.TICK", 32'(tick),  1);
    checkOutput("pre.CLK",  32'(clkHz), 1);
    rstN = 1'b0;
    #1;
    checkOutput("async.OUT",  32'(out),   'h01);
    checkOutput("async.TICK", 32'(tick),  0);
    checkOutput("async.CLK",  32'(clkHz), 0);
    checkOutput("async.STEP", 32'(step),  0);
    @(posedge clock);
    #1;
    modelReset();
    rstN = 1'b1;
    for (int i = 0; i < DIV; i++) begin
      applyStimulus(1'b1);
      checkAll("postrst");
    end
    checkOutput("postrst.TICK", 32'(tick), 1);

    // Random EN, including toggles between ticks.
    doReset();
    for (int i = 0; i < 800; i++) begin
      applyStimulus(logic'($urandom_range(0, 1)));
      checkAll("rand");
    end

    // DIV=1 instance: tick and step every cycle, clk1hz toggling each cycle.
    checkOutput("div1.rstOUT", 32'(out1), 'h01);
    checkOutput("div1.rstTICK", 32'(tick1), 0);
    en1 = 1'b1;
    rst1N = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("div1.%0d.OUT", k),  32'(out1),   32'(seq[k]));
      checkOutput($sformatf("div1.%0d.TICK", k), 32'(tick1),  1);
      checkOutput($sformatf("div1.%0d.CLK", k),  32'(clkHz1), 32'(k % 2));
      checkOutput($sformatf("div1.%0d.STEP", k), 32'(step1),  1);
      checkOutput($sformatf("div1.%0d.WRAP", k), 32'(wrap1),  0);
    end

`ifdef PRNG_SEED_LOAD_EN
    // LOAD beats a coincident tick; a zero seed falls back to SEED and flags WRAP.
    doReset();
    for (int i = 0; i < DIV - 1; i++) applyStimulus(1'b1);
    seedIn = 8'h5C;
    load = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("load.OUT",  32'(out),  'h5C);
    checkOutput("load.STEP", 32'(step), 1);
    checkOutput("load.TICK", 32'(tick), 1);
    checkOutput("load.WRAP", 32'(wrap), 0);
    seedIn = 8'h00;
    en = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("load0.OUT",  32'(out),  'h01);
    checkOutput("load0.STEP", 32'(step), 1);
    checkOutput("load0.WRAP", 32'(wrap), 1);
    load = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("load.idleSTEP", 32'(step), 0);
    checkOutput("load.idleOUT",  32'(out),  'h01);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
